mux_scan_ctrl: RTL and testbench
================================

Name: mux_scan_ctrl

Overview:
- Upstream sequencer for the 8:1 byte multiplexer (eight 8-bit inputs, 3-bit select, 8-bit output Y).
- On a start pulse it steps the mux select through every enabled channel once and waits a programmable settling time at each channel.
- It registers Y and presents each sample downstream with its channel number on a valid/ready handshake.
- It pulses frame_done when the scan completes.

Parameters:
- DW, 8, data width; must equal the mux data width.
- SETTLE_CYC, 2, clock cycles between a mux_sel change and capture of mux_y. Legal range 1..15.

Ports:
- sys_clk  in  1  system clock, rising edge.
- sys_rst  in  1  asynchronous reset, active-high.
- start  in  1  single-cycle scan request.
- stop  in  1  single-cycle abort request.
- ch_mask  in  8  channel enable mask, bit i = channel i. Latched at accepted start.
- mux_sel  out  3  drives the mux SEL input.
- mux_y  in  DW  mux Y output.
- samp_data  out  DW  captured sample.
- samp_ch  out  3  channel number of samp_data.
- samp_valid  out  1  sample available.
- samp_ready  in  1  downstream accepts the sample.
- busy  out  1  high in any state other than IDLE.
- frame_done  out  1  one-cycle pulse on completion of a full scan.

Behaviour:
- Reset (asynchronous, sys_rst=1):
  - All outputs go to 0.
  - State goes to IDLE; settle counter, latched mask and abort flag are cleared.
- States are IDLE, SETTLE and HOLD.
- IDLE:
  - start=1 with ch_mask!=0: latch ch_mask and set mux_sel to the lowest set bit index. Clear the counter, go to SETTLE, and set busy=1 on the same edge.
  - start=1 with ch_mask==0: ignored. Stay in IDLE, no frame_done.
- SETTLE:
  - The counter increments each cycle.
  - On the edge where counter==SETTLE_CYC-1: samp_data<=mux_y, samp_ch<=mux_sel, samp_valid<=1, go to HOLD.
  - Sample latency is therefore SETTLE_CYC clocks after mux_sel changes.
- HOLD:
  - samp_valid, samp_data and samp_ch stay stable until samp_valid&&samp_ready.
  - On that handshake edge samp_valid<=0, then:
    - If the latched mask has a set bit above mux_sel: mux_sel<=next set index, clear the counter, go to SETTLE. Disabled channels are skipped with zero cycles spent.
    - Otherwise: frame_done=1 for one cycle, go to IDLE, busy<=0. mux_sel keeps the last channel.
- Backpressure: the block can wait in HOLD indefinitely. No samples are dropped or overwritten.
- stop:
  - In IDLE: no effect.
  - In SETTLE: go to IDLE immediately. No sample is produced and there is no frame_done.
  - In HOLD: set an abort flag. The pending sample is still delivered; after its handshake go to IDLE without frame_done.
  - stop and start in the same cycle while IDLE: start wins.
- start while busy: ignored. ch_mask changes mid-scan have no effect.
- The final channel is the highest set bit in the latched mask. Channel 7 → IDLE, and mux_sel never wraps within a frame.
- Reset asserted mid-scan: everything returns to reset values asynchronously, and any pending sample is discarded.
- Throughput: with samp_ready tied high, each enabled channel takes SETTLE_CYC+1 cycles.

Test Plan:
- Mux model with A..H=0x11,0x22,...,0x88, ch_mask=0xFF, samp_ready=1, SETTLE_CYC=2, start pulse → eight samples (ch0,0x11)..(ch7,0x88) spaced 3 cycles apart. frame_done pulses 1 cycle after the (7,0x88) handshake, then busy=0.
- ch_mask=0xA4, start → exactly three samples: (2,0x33), (5,0x66), (7,0x88). mux_sel never takes the values 3, 4 or 6.
- ch_mask=0x03, samp_ready held low for 20 cycles after the first valid → samp_valid stays 1 and samp_data stays 0x11 throughout. After ready rises, (1,0x22) arrives 3 cycles later.
- ch_mask=0xFF, stop pulsed while in SETTLE for ch3 → samples for ch0..ch2 only, no frame_done, busy=0 the cycle after stop. A second start during the scan is ignored.
- start with ch_mask=0x00 → busy stays 0, no samp_valid, no frame_done. sys_rst pulsed while in HOLD → samp_valid=0 and mux_sel=0 immediately, state IDLE.

Source files
------------

// File: rtl/mux_scan_ctrl.sv
// Scan sequencer for an 8:1 byte mux: steps mux_sel through the enabled channels,
// waits a settling time on each, and hands every captured byte downstream on valid/ready.
module mux_scan_ctrl #(
  parameter int DW         = 8,
  parameter int SETTLE_CYC = 2
) (
  input  logic          sys_clk,
  input  logic          sys_rst,
  input  logic          start,
  input  logic          stop,
  input  logic [7:0]    ch_mask,
  output logic [2:0]    mux_sel,
  input  logic [DW-1:0] mux_y,
  output logic [DW-1:0] samp_data,
  output logic [2:0]    samp_ch,
  output logic          samp_valid,
  input  logic          samp_ready,
  output logic          busy,
  output logic          frame_done
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYC - 1);

  state_t     state_r;
  logic [3:0] cnt_r;
  logic [7:0] mask_r;
  logic       abort_r;
  logic       nxt_found_s;
  logic [2:0] nxt_ch_s;

  function automatic logic [2:0] lowest_ch(input logic [7:0] m);
    lowest_ch = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i]) lowest_ch = 3'(i);
    end
  endfunction

  // {found, index} of the lowest enabled channel strictly above cur; never wraps
  function automatic logic [3:0] next_ch(input logic [7:0] m, input logic [2:0] cur);
    next_ch = 4'd0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i] && (3'(i) > cur)) next_ch = {1'b1, 3'(i)};
    end
  endfunction

  // Next enabled channel after the one currently selected
  always_comb begin
    {nxt_found_s, nxt_ch_s} = next_ch(mask_r, mux_sel);
  end

  // Scan state machine with all outputs registered
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_r    <= IDLE;
      cnt_r      <= 4'd0;
      mask_r     <= 8'd0;
      abort_r    <= 1'b0;
      mux_sel    <= 3'd0;
      samp_data  <= '0;
      samp_ch    <= 3'd0;
      samp_valid <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start && (ch_mask != 8'd0)) begin
            mask_r  <= ch_mask;
            mux_sel <= lowest_ch(ch_mask);
            cnt_r   <= 4'd0;
            abort_r <= 1'b0;
            busy    <= 1'b1;
            state_r <= SETTLE;
          end
        end
        SETTLE: begin
          if (stop) begin
            cnt_r   <= 4'd0;
            busy    <= 1'b0;
            state_r <= IDLE;
          end else if (cnt_r == SETTLE_LAST) begin
            samp_data  <= mux_y;
            samp_ch    <= mux_sel;
            samp_valid <= 1'b1;
            cnt_r      <= 4'd0;
            state_r    <= HOLD;
          end else begin
            cnt_r <= cnt_r + 4'd1;
          end
        end
        HOLD: begin
          if (samp_valid && samp_ready) begin
            samp_valid <= 1'b0;
            // An abort raised while holding still lets the pending sample out first
            if (abort_r || stop) begin
              abort_r <= 1'b0;
              busy    <= 1'b0;
              state_r <= IDLE;
            end else if (nxt_found_s) begin
              mux_sel <= nxt_ch_s;
              cnt_r   <= 4'd0;
              state_r <= SETTLE;
            end else begin
              frame_done <= 1'b1;
              busy       <= 1'b0;
              state_r    <= IDLE;
            end
          end else if (stop) begin
            abort_r <= 1'b1;
          end
        end
        default: begin
          samp_valid <= 1'b0;
          busy       <= 1'b0;
          state_r    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed bench for mux_scan_ctrl: a behavioural 8:1 mux feeds the sequencer and
// each scenario task checks samples, timing and frame_done against hand-computed values.
module tb_mux_scan_ctrl;

  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic [7:0] ch_mask = 8'd0;
  logic [2:0] mux_sel;
  logic [7:0] mux_y;
  logic [7:0] samp_data;
  logic [2:0] samp_ch;
  logic       samp_valid;
  logic       samp_ready = 1'b1;
  logic       busy;
  logic       frame_done;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int fd_count = 0;
  int fd_cyc = 0;
  logic fd_busy = 1'b0;
  logic [7:0] sel_seen = 8'd0;

  typedef struct {
    logic [2:0] ch;
    logic [7:0] data;
    int         cyc;
  } samp_t;
  samp_t q[$];

  mux_scan_ctrl #(.DW(8), .SETTLE_CYC(2)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .start(start), .stop(stop),
    .ch_mask(ch_mask), .mux_sel(mux_sel), .mux_y(mux_y),
    .samp_data(samp_data), .samp_ch(samp_ch), .samp_valid(samp_valid),
    .samp_ready(samp_ready), .busy(busy), .frame_done(frame_done)
  );

  // Channels A..H carry 0x11, 0x22, ... 0x88
  always_comb mux_y = {1'b0, mux_sel} * 8'h11 + 8'h11;

  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) cyc++;

  always @(negedge sys_clk) begin
    if (samp_valid && samp_ready) q.push_back('{samp_ch, samp_data, cyc});
    if (frame_done) begin
      fd_count++;
      fd_cyc  = cyc;
      fd_busy = busy;
    end
    if (busy) sel_seen[mux_sel] = 1'b1;
  end

  task automatic clear_log();
    q.delete();
    fd_count = 0;
    sel_seen = 8'd0;
  endtask

  task automatic pulse_start(input logic [7:0] m);
    @(posedge sys_clk); #1;
    ch_mask = m;
    start = 1'b1;
    @(posedge sys_clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(posedge sys_clk); #1;
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (2) @(posedge sys_clk);
    #1;
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge sys_clk); #1;
      if (samp_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    sys_rst = 1'b1;
    #3;
    total++; if (mux_sel !== 3'd0) begin bad++; $display("FAIL reset_sel got=%0d exp=0", mux_sel); end
    total++; if (samp_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", samp_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL reset_fd got=%b exp=0", frame_done); end
    total++; if (samp_data !== 8'h00 || samp_ch !== 3'd0) begin bad++; $display("FAIL reset_data got=%0d/%h exp=0/00", samp_ch, samp_data); end
    @(posedge sys_clk); #1;
    sys_rst = 1'b0;
    repeat (2) @(posedge sys_clk);
    #1;
  endtask

  task automatic test_full_scan();
    bit ok;
    clear_log();
    samp_ready = 1'b1;
    pulse_start(8'hFF);
    wait_idle(ok);
    total++; if (!ok) begin bad++; $display("FAIL full_timeout got=busy exp=idle"); end
    total++; if (q.size() != 8) begin bad++; $display("FAIL full_count got=%0d exp=8", q.size()); end
    for (int i = 0; i < 8 && i < q.size(); i++) begin
      logic [7:0] ev;
      ev = 8'(i + 1) * 8'h11;
      total++;
      if (q[i].ch !== 3'(i) || q[i].data !== ev) begin
        bad++; $display("FAIL full_samp%0d got=(%0d,%h) exp=(%0d,%h)", i, q[i].ch, q[i].data, i, ev);
      end
      if (i > 0) begin
        total++;
        if (q[i].cyc - q[i-1].cyc != 3) begin
          bad++; $display("FAIL full_gap%0d got=%0d exp=3", i, q[i].cyc - q[i-1].cyc);
        end
      end
    end
    total++; if (fd_count != 1) begin bad++; $display("FAIL full_fd_count got=%0d exp=1", fd_count); end
    if (q.size() == 8) begin
      total++; if (fd_cyc != q[7].cyc + 1) begin bad++; $display("FAIL full_fd_time got=%0d exp=%0d", fd_cyc, q[7].cyc + 1); end
    end
    total++; if (fd_busy !== 1'b0) begin bad++; $display("FAIL full_fd_busy got=%b exp=0", fd_busy); end
    total++; if (mux_sel !== 3'd7) begin bad++; $display("FAIL full_last_sel got=%0d exp=7", mux_sel); end
  endtask

  task automatic test_sparse_mask();
    bit ok;
    clear_log();
    pulse_start(8'hA4);
    wait_idle(ok);
    total++; if (!ok) begin bad++; $display("FAIL sparse_timeout got=busy exp=idle"); end
    total++; if (q.size() != 3) begin bad++; $display("FAIL sparse_count got=%0d exp=3", q.size()); end
    if (q.size() == 3) begin
      total++; if (q[0].ch !== 3'd2 || q[0].data !== 8'h33) begin bad++; $display("FAIL sparse_s0 got=(%0d,%h) exp=(2,33)", q[0].ch, q[0].data); end
      total++; if (q[1].ch !== 3'd5 || q[1].data !== 8'h66) begin bad++; $display("FAIL sparse_s1 got=(%0d,%h) exp=(5,66)", q[1].ch, q[1].data); end
      total++; if (q[2].ch !== 3'd7 || q[2].data !== 8'h88) begin bad++; $display("FAIL sparse_s2 got=(%0d,%h) exp=(7,88)", q[2].ch, q[2].data); end
      total++; if (q[1].cyc - q[0].cyc != 3) begin bad++; $display("FAIL sparse_skip_gap got=%0d exp=3", q[1].cyc - q[0].cyc); end
    end
    total++; if (sel_seen[3] || sel_seen[4] || sel_seen[6]) begin bad++; $display("FAIL sparse_sel_seen got=%b exp=skip 3,4,6", sel_seen); end
    total++; if (fd_count != 1) begin bad++; $display("FAIL sparse_fd got=%0d exp=1", fd_count); end
  endtask

  task automatic test_backpressure();
    bit ok;
    clear_log();
    samp_ready = 1'b0;
    pulse_start(8'h03);
    wait_valid(ok);
    total++; if (!ok) begin bad++; $display("FAIL bp_valid_timeout got=0 exp=1"); end
    for (int i = 0; i < 20; i++) begin
      @(negedge sys_clk);
      total++;
      if (samp_valid !== 1'b1 || samp_data !== 8'h11) begin
        bad++; $display("FAIL bp_hold%0d got=%b/%h exp=1/11", i, samp_valid, samp_data);
      end
    end
    @(posedge sys_clk); #1;
    samp_ready = 1'b1;
    wait_idle(ok);
    total++; if (q.size() != 2) begin bad++; $display("FAIL bp_count got=%0d exp=2", q.size()); end
    if (q.size() == 2) begin
      total++; if (q[0].ch !== 3'd0 || q[0].data !== 8'h11) begin bad++; $display("FAIL bp_s0 got=(%0d,%h) exp=(0,11)", q[0].ch, q[0].data); end
      total++; if (q[1].ch !== 3'd1 || q[1].data !== 8'h22) begin bad++; $display("FAIL bp_s1 got=(%0d,%h) exp=(1,22)", q[1].ch, q[1].data); end
      total++; if (q[1].cyc - q[0].cyc != 3) begin bad++; $display("FAIL bp_gap got=%0d exp=3", q[1].cyc - q[0].cyc); end
    end
  endtask

  task automatic test_stop();
    bit ok;
    clear_log();
    samp_ready = 1'b1;
    pulse_start(8'hFF);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(posedge sys_clk); #1;
      if (q.size() >= 1) begin ok = 1'b1; break; end
    end
    total++; if (!ok) begin bad++; $display("FAIL stop_first_timeout got=0 exp=1"); end
    ch_mask = 8'h01;
    start = 1'b1;
    @(posedge sys_clk); #1;
    start = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(posedge sys_clk); #1;
      if (mux_sel == 3'd3 && busy && !samp_valid) begin ok = 1'b1; break; end
    end
    total++; if (!ok) begin bad++; $display("FAIL stop_ch3_timeout got=%0d exp=3", mux_sel); end
    stop = 1'b1;
    @(posedge sys_clk); #1;
    stop = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL stop_busy got=%b exp=0", busy); end
    repeat (6) @(posedge sys_clk);
    #1;
    total++; if (q.size() != 3) begin bad++; $display("FAIL stop_count got=%0d exp=3", q.size()); end
    for (int i = 0; i < 3 && i < q.size(); i++) begin
      total++;
      if (q[i].ch !== 3'(i)) begin bad++; $display("FAIL stop_ch%0d got=%0d exp=%0d", i, q[i].ch, i); end
    end
    total++; if (fd_count != 0) begin bad++; $display("FAIL stop_fd got=%0d exp=0", fd_count); end
    total++; if (samp_valid !== 1'b0) begin bad++; $display("FAIL stop_valid got=%b exp=0", samp_valid); end
  endtask

  task automatic test_empty_and_reset();
    bit ok;
    bit seen_busy;
    bit seen_valid;
    clear_log();
    pulse_start(8'h00);
    seen_busy = 1'b0;
    seen_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge sys_clk);
      if (busy) seen_busy = 1'b1;
      if (samp_valid) seen_valid = 1'b1;
    end
    total++; if (seen_busy) begin bad++; $display("FAIL empty_busy got=1 exp=0"); end
    total++; if (seen_valid) begin bad++; $display("FAIL empty_valid got=1 exp=0"); end
    total++; if (fd_count != 0) begin bad++; $display("FAIL empty_fd got=%0d exp=0", fd_count); end
    samp_ready = 1'b0;
    pulse_start(8'hF0);
    wait_valid(ok);
    total++; if (!ok || mux_sel !== 3'd4) begin bad++; $display("FAIL hold_entry got=%b/%0d exp=1/4", ok, mux_sel); end
    #2;
    sys_rst = 1'b1;
    #1;
    total++; if (samp_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_valid got=%b exp=0", samp_valid); end
    total++; if (mux_sel !== 3'd0) begin bad++; $display("FAIL rst_mid_sel got=%0d exp=0", mux_sel); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_mid_busy got=%b exp=0", busy); end
    @(posedge sys_clk); #1;
    sys_rst = 1'b0;
    repeat (4) @(posedge sys_clk);
    #1;
    total++; if (busy !== 1'b0 || samp_valid !== 1'b0) begin bad++; $display("FAIL rst_after got=%b/%b exp=0/0", busy, samp_valid); end
  endtask

  initial begin
    test_reset();
    test_full_scan();
    test_sparse_mask();
    test_backpressure();
    test_stop();
    test_empty_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
